// File: rtl/imm_gen_ctrl.sv
// Decode-stage immediate generator with a two-slot (MAIN/SKID) valid/ready buffer into ID/EX.
// Optional macro IMM_GEN_MOVW_EN compiles in MOVZ/MOVK (IW) decode and the halfword shifter.
module imm_gen_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_imm,
  output logic [2:0]  out_type,
  output logic [31:0] out_instr
);

  localparam logic [2:0] TYPE_NONE = 3'd0;
  localparam logic [2:0] TYPE_I    = 3'd1;
  localparam logic [2:0] TYPE_D    = 3'd2;
  localparam logic [2:0] TYPE_B    = 3'd3;
  localparam logic [2:0] TYPE_CB   = 3'd4;
`ifdef IMM_GEN_MOVW_EN
  localparam logic [2:0] TYPE_IW   = 3'd5;
`endif

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  kind;
  } beat_t;

  state_t state_q, state_d;
  beat_t  main_q, main_d;
  beat_t  skid_q, skid_d;
  logic   in_ready_q, in_ready_d;

  logic [2:0]  dec_type;
  logic [63:0] dec_imm;
  beat_t       new_beat;
  logic        accept;
  logic        drain;

  // Combinational classification; first matching format wins.
  always_comb begin
    dec_type = TYPE_NONE;
    dec_imm  = 64'd0;
    if (in_instr[31:22] == 10'b1001000100 || in_instr[31:22] == 10'b1011000100 ||
        in_instr[31:22] == 10'b1101000100 || in_instr[31:22] == 10'b1111000100) begin
      dec_type = TYPE_I;
      dec_imm  = {52'd0, in_instr[21:10]};
    end else if (in_instr[31:21] == 11'b11111000010 || in_instr[31:21] == 11'b11111000000) begin
      dec_type = TYPE_D;
      dec_imm  = {{55{in_instr[20]}}, in_instr[20:12]};
    end else if (in_instr[31:26] == 6'b000101) begin
      dec_type = TYPE_B;
      dec_imm  = {{36{in_instr[25]}}, in_instr[25:0], 2'b00};
    end else if (in_instr[31:24] == 8'b10110100 || in_instr[31:24] == 8'b01010100) begin
      dec_type = TYPE_CB;
      dec_imm  = {{43{in_instr[23]}}, in_instr[23:5], 2'b00};
    end
`ifdef IMM_GEN_MOVW_EN
    else if (in_instr[31:23] == 9'b110100101 || in_instr[31:23] == 9'b111100101) begin
      dec_type = TYPE_IW;
      dec_imm  = {48'd0, in_instr[20:5]} << {in_instr[22:21], 4'b0000};
    end
`endif
  end

  assign new_beat = '{instr: in_instr, imm: dec_imm, kind: dec_type};

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = in_ready_q;
  assign accept    = in_valid & in_ready_q;
  assign drain     = out_valid & out_ready;

  // Empty slots are kept zeroed so the outputs read 0 whenever out_valid is low.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = new_beat;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_d = new_beat;
          end else if (accept) begin
            skid_d  = new_beat;
            state_d = ST_TWO;
          end else if (drain) begin
            main_d  = '0;
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (drain) begin
            main_d  = skid_q;
            skid_d  = '0;
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign out_imm   = main_q.imm;
  assign out_type  = main_q.kind;
  assign out_instr = main_q.instr;

endmodule

// File: tb/tb_imm_gen_ctrl.sv
// Directed self-checking bench for imm_gen_ctrl; honours IMM_GEN_MOVW_EN for the MOVZ/MOVK expectations.
module tb_imm_gen_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_imm;
  logic [2:0]  out_type;
  logic [31:0] out_instr;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] ADDI  = 32'h913FFC41;
  localparam logic [31:0] LDUR  = 32'hF85F8020;
  localparam logic [31:0] BNEG  = 32'h17FFFFFF;
  localparam logic [31:0] CBZ   = 32'hB4000040;
  localparam logic [31:0] BCOND = 32'h54FFFFE0;
  localparam logic [31:0] SUBSI = 32'hF1000421;
  localparam logic [31:0] NOPW  = 32'h00000000;
  localparam logic [31:0] MOVK  = 32'hF2E24680;
  localparam logic [31:0] MOVZ  = 32'hD2800020;

  imm_gen_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_type  (out_type),
    .out_instr (out_instr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [31:0] instr,
                           input logic [2:0] kind, input logic [63:0] imm);
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    check({tag, "_type"},  {61'd0, out_type},  {61'd0, kind});
    check({tag, "_imm"},   out_imm,            imm);
    check({tag, "_instr"}, {32'd0, out_instr}, {32'd0, instr});
    $display("txn %s: type=%0d imm=%h instr=%h", tag, out_type, out_imm, out_instr);
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_type"},  {61'd0, out_type},  64'd0);
    check({tag, "_imm"},   out_imm,            64'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'd0;
    flush     = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check_empty("reset");
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_instr", {32'd0, out_instr}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // ADDI, then LDUR and B back-to-back at full throughput
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = ADDI;
    tick();
    check_out("addi", ADDI, 3'd1, 64'h0000_0000_0000_0FFF);
    in_instr = LDUR;
    tick();
    check_out("ldur", LDUR, 3'd2, 64'hFFFF_FFFF_FFFF_FFF8);
    in_instr = BNEG;
    tick();
    check_out("bneg", BNEG, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC);
    in_instr = CBZ;
    tick();
    check_out("cbz", CBZ, 3'd4, 64'h0000_0000_0000_0008);
    in_instr = BCOND;
    tick();
    check_out("bcond", BCOND, 3'd4, 64'hFFFF_FFFF_FFFF_FFFC);
    in_instr = SUBSI;
    tick();
    check_out("subsi", SUBSI, 3'd1, 64'h0000_0000_0000_0001);
    in_instr = NOPW;
    tick();
    check_out("none", NOPW, 3'd0, 64'd0);
    in_instr = MOVK;
    tick();
`ifdef IMM_GEN_MOVW_EN
    check_out("movk", MOVK, 3'd5, 64'h1234_0000_0000_0000);
`else
    check_out("movk", MOVK, 3'd0, 64'd0);
`endif
    in_instr = MOVZ;
    tick();
`ifdef IMM_GEN_MOVW_EN
    check_out("movz", MOVZ, 3'd5, 64'h0000_0000_0000_0001);
`else
    check_out("movz", MOVZ, 3'd0, 64'd0);
`endif
    in_valid = 1'b0;
    tick();
    check_empty("drained");
    check("drained_instr", {32'd0, out_instr}, 64'd0);

    // Backpressure: three beats offered while stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = ADDI;
    tick();
    check_out("bp_a", ADDI, 3'd1, 64'h0000_0000_0000_0FFF);
    check("bp_a_in_ready", {63'd0, in_ready}, 64'd1);
    in_instr = LDUR;
    tick();
    check("bp_b_in_ready", {63'd0, in_ready}, 64'd0);
    check_out("bp_hold1", ADDI, 3'd1, 64'h0000_0000_0000_0FFF);
    in_instr = BNEG;
    tick();
    check("bp_c_in_ready", {63'd0, in_ready}, 64'd0);
    check_out("bp_hold2", ADDI, 3'd1, 64'h0000_0000_0000_0FFF);
    out_ready = 1'b1;
    tick();
    check_out("bp_out_b", LDUR, 3'd2, 64'hFFFF_FFFF_FFFF_FFF8);
    check("bp_refill_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    check_out("bp_out_c", BNEG, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC);
    in_valid = 1'b0;
    tick();
    check_empty("bp_done");

    // Flush while TWO with a beat on the input
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = CBZ;
    tick();
    in_instr = SUBSI;
    tick();
    check("fl_two_in_ready", {63'd0, in_ready}, 64'd0);
    in_instr = LDUR;
    flush    = 1'b1;
    tick();
    check_empty("flush");
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_empty("post_flush");

    // Asynchronous reset while ONE, between edges
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = ADDI;
    tick();
    check_out("pre_rst", ADDI, 3'd1, 64'h0000_0000_0000_0FFF);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_empty("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("rst_rel_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_rel_valid", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = LDUR;
    tick();
    check_out("post_rst", LDUR, 3'd2, 64'hFFFF_FFFF_FFFF_FFF8);
    in_valid = 1'b0;
    tick();
    check_empty("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
